plot_arbiter: RTL and testbench
===============================

PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 20000: maximum number of cycles one grant may be held (covers a full 160x120 frame, 19200 pixels).
REQ-002 SHALL have port clock, input, 1: the single system clock (CLOCK_50 at top level); all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 4: per-requester request for the VGA plot port (splash, word slots, gallows, victory/death).
REQ-005 SHALL have port rel, input, 4: per-requester release pulse (drawing done).
REQ-006 SHALL have port x_in, input, 32: four packed 8-bit x coordinates; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port y_in, input, 28: four packed 7-bit y coordinates; requester i uses bits [7i+6:7i].
REQ-008 SHALL have port colour_in, input, 12: four packed 3-bit colours; requester i uses bits [3i+2:3i].
REQ-009 SHALL have port plot_in, input, 4: per-requester pixel-write strobe.
REQ-010 SHALL have port gnt, output, 4: registered one-hot grant, all-zero when no grant is held.
REQ-011 SHALL have port busy, output, 1: high while any grant is held.
REQ-012 SHALL have ports x, output, 8; y, output, 7; colour, output, 3; plot, output, 1: registered feed to vga_adapter.
REQ-013 SHALL have port timeout_err, output, 1: one-cycle pulse when a grant is revoked by timeout.

Function
REQ-014 SHALL implement FSM states IDLE, ACTIVE and GAP.
REQ-015 In IDLE with req nonzero, SHALL select the winner round-robin: search indices ptr, ptr+1, ptr+2, ptr+3 (mod 4) and take the first with req set.
REQ-016 SHALL set gnt to the winner's one-hot on the next edge, clear the timer to 0, and enter ACTIVE; req rising at cycle n SHALL give gnt at cycle n+1.
REQ-017 In IDLE with req zero, SHALL stay in IDLE with gnt = 0.
REQ-018 In ACTIVE, SHALL register x/y/colour/plot from the granted slice with a latency of 1 cycle.
REQ-019 SHALL never forward plot_in from a non-granted requester; plot SHALL be 0 whenever no grant was held in the previous cycle.
REQ-020 In ACTIVE, if rel[g] = 1 or req[g] = 0 for granted index g, SHALL go to GAP, clear gnt, and set ptr = (g+1) mod 4.
REQ-021 A pixel presented on the same cycle as rel[g] SHALL still be forwarded.
REQ-022 rel on a non-granted index SHALL be ignored.
REQ-023 In ACTIVE, the timer SHALL increment each cycle.
REQ-024 When the timer reaches TIMEOUT-1 without release, SHALL pulse timeout_err for one cycle, go to GAP, clear gnt, and advance ptr as in REQ-020.
REQ-025 If release and timeout coincide, release SHALL take precedence (no timeout_err).
REQ-026 GAP SHALL last exactly one cycle with plot = 0, then go to IDLE, so each handover costs 2 idle cycles.
REQ-027 busy SHALL equal |gnt.
REQ-028 Arbitration SHALL be starvation-free: with all four requesting continuously, grants SHALL rotate 0,1,2,3,0,...
REQ-029 Timer width SHALL be ceil(log2(TIMEOUT)) bits and SHALL not wrap within a grant.

Reset
REQ-030 While resetn = 0, SHALL asynchronously force: state IDLE; gnt = 0; busy = 0; ptr = 0; timer = 0; x = 0; y = 0; colour = 0; plot = 0; timeout_err = 0.
REQ-031 Reset asserted mid-grant SHALL drop the grant and plot immediately, with no timeout_err.
REQ-032 After reset, requester 0 SHALL have first priority.

Verification
REQ-033 After reset, req = 4'b1010 -> gnt = 4'b0010 one cycle later; busy = 1.
REQ-034 Granted requester 1 drives plot_in[1] = 1, x = 8'd37, y = 7'd90, colour = 3'b101 -> next cycle x = 37, y = 90, colour = 5, plot = 1; a simultaneous plot_in[3] = 1 is not forwarded.
REQ-035 req = 4'b1111 held; each holder pulses rel after 3 cycles -> grant order 0,1,2,3,0; 2 dead cycles with plot = 0 between grants.
REQ-036 TIMEOUT = 8; requester 2 holds req with no rel -> timeout_err pulses at cycle 8 of the grant; gnt = 0; the next grant goes to 3 if requesting.
REQ-037 resetn pulsed low mid-ACTIVE while plot = 1 -> gnt, plot and busy are 0 without waiting for a clock edge; after release, req = 4'b0110 -> gnt = 4'b0010.

Source files
------------

// File: rtl/plot_arbiter.sv
// Round-robin arbiter that grants one of four drawing engines exclusive access
// to the VGA plot port, with a watchdog that revokes stuck grants.
module plot_arbiter #(
  parameter int TIMEOUT = 20000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [3:0]  rel,
  input  logic [31:0] x_in,
  input  logic [27:0] y_in,
  input  logic [11:0] colour_in,
  input  logic [3:0]  plot_in,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        timeout_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    r_ptr;
  logic [1:0]    r_gidx;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_gnt;
  logic          r_busy;
  logic [7:0]    r_x;
  logic [6:0]    r_y;
  logic [2:0]    r_colour;
  logic          r_plot;
  logic          r_terr;

  logic [1:0]    w_state_nxt;
  logic [1:0]    w_ptr_nxt;
  logic [1:0]    w_gidx_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic [3:0]    w_gnt_nxt;
  logic          w_terr_nxt;
  logic [7:0]    w_x_nxt;
  logic [6:0]    w_y_nxt;
  logic [2:0]    w_colour_nxt;
  logic          w_plot_nxt;

  logic          w_win_found;
  logic [1:0]    w_win_idx;
  logic [1:0]    w_cand;
  logic          w_release;
  logic          w_timeout;

  logic [7:0]    w_x_arr [4];
  logic [6:0]    w_y_arr [4];
  logic [2:0]    w_c_arr [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    assign w_x_arr[gi] = x_in[8*gi +: 8];
    assign w_y_arr[gi] = y_in[7*gi +: 7];
    assign w_c_arr[gi] = colour_in[3*gi +: 3];
  end

  // Round-robin search; walking downward lets the nearest index to ptr win.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = r_ptr;
    w_cand      = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_ptr + 2'(k);
      if (req[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end else begin
        w_win_found = w_win_found;
      end
    end
  end

  assign w_release = rel[r_gidx] | ~req[r_gidx];
  assign w_timeout = (r_timer == TMAX);

  // Next-state logic for the grant FSM, pointer and watchdog timer.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gidx_nxt  = r_gidx;
    w_timer_nxt = r_timer;
    w_gnt_nxt   = r_gnt;
    w_terr_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_state_nxt = S_ACTIVE;
          w_gnt_nxt   = 4'b0001 << w_win_idx;
          w_gidx_nxt  = w_win_idx;
          w_timer_nxt = '0;
        end else begin
          w_gnt_nxt   = 4'b0000;
        end
      end
      S_ACTIVE: begin
        // Release wins over a coincident timeout, so no error is flagged then.
        if (w_release) begin
          w_state_nxt = S_GAP;
          w_gnt_nxt   = 4'b0000;
          w_ptr_nxt   = r_gidx + 2'd1;
        end else if (w_timeout) begin
          w_state_nxt = S_GAP;
          w_gnt_nxt   = 4'b0000;
          w_ptr_nxt   = r_gidx + 2'd1;
          w_terr_nxt  = 1'b1;
        end else begin
          w_timer_nxt = r_timer + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 4'b0000;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 4'b0000;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Pixel mux: only the granted slice is ever forwarded to the adapter.
  always_comb begin
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_colour_nxt = r_colour;
    w_plot_nxt   = 1'b0;
    if (r_state == S_ACTIVE) begin
      w_x_nxt      = w_x_arr[r_gidx];
      w_y_nxt      = w_y_arr[r_gidx];
      w_colour_nxt = w_c_arr[r_gidx];
      w_plot_nxt   = plot_in[r_gidx];
    end else begin
      w_plot_nxt   = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_ptr    <= 2'd0;
      r_gidx   <= 2'd0;
      r_timer  <= '0;
      r_gnt    <= 4'b0000;
      r_busy   <= 1'b0;
      r_x      <= 8'd0;
      r_y      <= 7'd0;
      r_colour <= 3'd0;
      r_plot   <= 1'b0;
      r_terr   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_gidx   <= w_gidx_nxt;
      r_timer  <= w_timer_nxt;
      r_gnt    <= w_gnt_nxt;
      r_busy   <= |w_gnt_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_colour <= w_colour_nxt;
      r_plot   <= w_plot_nxt;
      r_terr   <= w_terr_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign busy        = r_busy;
  assign x           = r_x;
  assign y           = r_y;
  assign colour      = r_colour;
  assign plot        = r_plot;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter (TIMEOUT = 8) using expected-value queues.
module tb_plot_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic [3:0]  req;
  logic [3:0]  rel;
  logic [31:0] x_in;
  logic [27:0] y_in;
  logic [11:0] colour_in;
  logic [3:0]  plot_in;
  logic [3:0]  gnt;
  logic        busy;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        timeout_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [18:0] pix_q [$];
  logic [3:0]  gnt_q [$];
  logic [18:0] pix_exp;
  logic [3:0]  gnt_exp;

  plot_arbiter #(.TIMEOUT(8)) dut (
    .clock(clock), .resetn(resetn), .req(req), .rel(rel),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .plot_in(plot_in),
    .gnt(gnt), .busy(busy), .x(x), .y(y), .colour(colour), .plot(plot),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = 4'b0000; rel = 4'b0000; plot_in = 4'b0000;
    x_in = 32'd0; y_in = 28'd0; colour_in = 12'd0;
    tick(); tick();
    tests_run++;
    if ({gnt, busy, plot, timeout_err} !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: gnt=%b busy=%b plot=%b terr=%b, want all 0", gnt, busy, plot, timeout_err);
    end
    tests_run++;
    if ({x, y, colour} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_pixel: x=%0d y=%0d colour=%0d, want 0", x, y, colour);
    end
    #3 resetn = 1'b1;
    tick();
  endtask

  task automatic test_first_grant();
    req = 4'b1010;
    tick();
    tests_run++;
    if (gnt !== 4'b0010 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_grant: gnt=%b busy=%b, want 0010 1", gnt, busy);
    end
  endtask

  task automatic test_pixel();
    x_in = {8'd200, 8'd0, 8'd37, 8'd0};
    y_in = {7'd11, 7'd0, 7'd90, 7'd0};
    colour_in = {3'd2, 3'd0, 3'd5, 3'd0};
    plot_in = 4'b1010;
    pix_q.push_back({8'd37, 7'd90, 3'd5, 1'b1});
    tick();
    pix_exp = pix_q.pop_front();
    tests_run++;
    if ({x, y, colour, plot} !== pix_exp) begin
      tests_failed++;
      $display("FAIL pixel_fwd: got x=%0d y=%0d c=%0d p=%b, want %h", x, y, colour, plot, pix_exp);
    end
    plot_in = 4'b1000;
    pix_q.push_back({8'd37, 7'd90, 3'd5, 1'b0});
    tick();
    pix_exp = pix_q.pop_front();
    tests_run++;
    if ({x, y, colour, plot} !== pix_exp) begin
      tests_failed++;
      $display("FAIL pixel_foreign_plot: got x=%0d y=%0d c=%0d p=%b, want %h", x, y, colour, plot, pix_exp);
    end
    rel = 4'b1000;
    tick();
    tests_run++;
    if (gnt !== 4'b0010) begin
      tests_failed++;
      $display("FAIL foreign_rel: gnt=%b, want 0010", gnt);
    end
    rel = 4'b0010; plot_in = 4'b0010;
    x_in = {8'd200, 8'd0, 8'd12, 8'd0};
    pix_q.push_back({8'd12, 7'd90, 3'd5, 1'b1});
    tick();
    pix_exp = pix_q.pop_front();
    tests_run++;
    if ({x, y, colour, plot} !== pix_exp || gnt !== 4'b0000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_pixel: got x=%0d p=%b gnt=%b busy=%b, want %h gnt 0", x, plot, gnt, busy, pix_exp);
    end
    rel = 4'b0000; plot_in = 4'b1010;
    tick();
    tests_run++;
    if (gnt !== 4'b0000 || plot !== 1'b0) begin
      tests_failed++;
      $display("FAIL gap_dead: gnt=%b plot=%b, want 0 0", gnt, plot);
    end
    tick();
    tests_run++;
    if (gnt !== 4'b1000) begin
      tests_failed++;
      $display("FAIL rr_next: gnt=%b, want 1000", gnt);
    end
    req = 4'b0000; plot_in = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_rotation();
    logic [3:0] prev_gnt;
    int hold, dead, ngrants;
    bit first, done;
    prev_gnt = 4'b0000; hold = 0; dead = 0; ngrants = 0; first = 1'b1; done = 1'b0;
    gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0010); gnt_q.push_back(4'b0100);
    gnt_q.push_back(4'b1000); gnt_q.push_back(4'b0001);
    req = 4'b1111; plot_in = 4'b1111;
    for (int c = 0; c < 80 && !done; c++) begin
      tick();
      if (gnt !== 4'b0000) begin
        if (prev_gnt === 4'b0000) begin
          ngrants++;
          gnt_exp = (gnt_q.size() > 0) ? gnt_q.pop_front() : 4'bxxxx;
          tests_run++;
          if (gnt !== gnt_exp) begin
            tests_failed++;
            $display("FAIL rotation_order: grant %0d gnt=%b, want %b", ngrants, gnt, gnt_exp);
          end
          if (!first) begin
            tests_run++;
            if (dead != 2) begin
              tests_failed++;
              $display("FAIL rotation_gap: dead=%0d, want 2", dead);
            end
          end
          first = 1'b0; hold = 0; dead = 0;
        end
        hold++;
        if (hold >= 2) begin
          tests_run++;
          if (plot !== 1'b1) begin
            tests_failed++;
            $display("FAIL rotation_plot: plot=%b, want 1", plot);
          end
        end
        if (hold == 3) begin
          rel = gnt; plot_in = 4'b0000;
          if (ngrants == 5) done = 1'b1;
        end else begin
          rel = 4'b0000; plot_in = 4'b1111;
        end
      end else begin
        rel = 4'b0000; plot_in = 4'b1111;
        dead++;
        tests_run++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL rotation_dead_plot: plot=%b busy=%b, want 0 0", plot, busy);
        end
      end
      prev_gnt = gnt;
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL rotation_budget: grants=%0d, want 5 within budget", ngrants);
    end
    tick();
    req = 4'b0000; rel = 4'b0000; plot_in = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    req = 4'b1100;
    tick();
    tests_run++;
    if (gnt !== 4'b0100) begin
      tests_failed++;
      $display("FAIL to_grant: gnt=%b, want 0100", gnt);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      tests_run++;
      if (gnt !== 4'b0100 || timeout_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL to_hold: cycle %0d gnt=%b terr=%b, want 0100 0", i, gnt, timeout_err);
      end
    end
    tick();
    tests_run++;
    if (timeout_err !== 1'b1 || gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL to_pulse: terr=%b gnt=%b, want 1 0000", timeout_err, gnt);
    end
    tick();
    tests_run++;
    if (timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_one_cycle: terr=%b, want 0", timeout_err);
    end
    gnt_q.push_back(4'b1000);
    tick();
    gnt_exp = gnt_q.pop_front();
    tests_run++;
    if (gnt !== gnt_exp) begin
      tests_failed++;
      $display("FAIL to_next: gnt=%b, want %b", gnt, gnt_exp);
    end
    for (int i = 1; i < 8; i++) tick();
    rel = 4'b1000;
    tick();
    tests_run++;
    if (timeout_err !== 1'b0 || gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rel_vs_timeout: terr=%b gnt=%b, want 0 0000", timeout_err, gnt);
    end
    rel = 4'b0000; req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    req = 4'b0001; plot_in = 4'b0001;
    tick();
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || plot !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_setup: gnt=%b plot=%b, want 0001 1", gnt, plot);
    end
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if (gnt !== 4'b0000 || plot !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: gnt=%b plot=%b busy=%b terr=%b, want 0", gnt, plot, busy, timeout_err);
    end
    req = 4'b0110; plot_in = 4'b0000;
    tick();
    #3 resetn = 1'b1;
    tick();
    tests_run++;
    if (gnt !== 4'b0010) begin
      tests_failed++;
      $display("FAIL post_reset_prio: gnt=%b, want 0010", gnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_pixel();
    test_rotation();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
